ref_nco_tracker: RTL

//  Generates the signed 10-bit reference sinusoid that the lp_filter correlator multiplies

---
 rtl/ref_nco_tracker_if.sv | 35 +++
 rtl/ref_nco_tracker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ref_nco_tracker_if.sv
// ref_nco_tracker_if
//   Bundles the sample/loop-control inputs and the reference/status outputs
//   of ref_nco_tracker so the block drops in as a single bus.
// Signals
//   sample_en     1   one-cycle strobe, one per sample
//   enable        1   1 = run the phase search loop, 0 = go idle
//   adjust        1   correlation-above-threshold flag from lp_filter
//   ref_out       10  signed reference sample, -511..+511
//   ref_valid     1   one-cycle pulse, ref_out updated this cycle
//   locked        1   high while the loop holds correlation
//   phase_offset  32  offset currently added to the phase accumulator
//   sweep_wrap    1   one-cycle pulse when phase_offset wraps past 2^32
// Modports
//   master  drives the strobe/control inputs, observes the outputs
//   slave   the tracker itself
interface ref_nco_tracker_if;
    logic              sample_en;
    logic              enable;
    logic              adjust;
    logic signed [9:0] ref_out;
    logic              ref_valid;
    logic              locked;
    logic [31:0]       phase_offset;
    logic              sweep_wrap;

    modport master (
        output sample_en, enable, adjust,
        input  ref_out, ref_valid, locked, phase_offset, sweep_wrap
    );

    modport slave (
        input  sample_en, enable, adjust,
        output ref_out, ref_valid, locked, phase_offset, sweep_wrap
    );
endinterface

// File: rtl/ref_nco_tracker.sv
// ref_nco_tracker
//   NCO producing the signed 10-bit reference sinusoid for the lp_filter
//   correlator, plus the phase search loop that steps the reference phase
//   offset until lp_filter reports sustained correlation ('adjust').
// Ports
//   clk        system clock
//   sys_rst_n  asynchronous active-low reset
//   bus        ref_nco_tracker_if.slave: sample_en/enable/adjust in,
//              ref_out/ref_valid/locked/phase_offset/sweep_wrap out
// Datapath latency: sample_en -> ref_valid is 2 clocks.
module ref_nco_tracker #(
    parameter logic [31:0] FCW        = 32'h0400_0000,
    parameter logic [31:0] PHASE_STEP = 32'h0800_0000,
    parameter int unsigned SETTLE_CNT = 80,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned LOSS_CNT   = 16
) (
    input logic              clk,
    input logic              sys_rst_n,
    ref_nco_tracker_if.slave bus
);

    localparam int unsigned SW = $clog2(SETTLE_CNT + 1);
    localparam int unsigned HW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(LOSS_CNT + 1);

    // Quarter-wave table: round(511*sin(pi/2*(i+0.5)/64)). The half-step
    // offset makes the fold symmetric, so no entry is ever zero.
    localparam logic [8:0] SINE_LUT [64] = '{
        9'd6,   9'd19,  9'd31,  9'd44,  9'd56,  9'd69,  9'd81,  9'd94,
        9'd106, 9'd118, 9'd130, 9'd142, 9'd154, 9'd166, 9'd178, 9'd190,
        9'd201, 9'd213, 9'd224, 9'd235, 9'd246, 9'd257, 9'd268, 9'd279,
        9'd289, 9'd299, 9'd309, 9'd319, 9'd329, 9'd338, 9'd348, 9'd357,
        9'd366, 9'd374, 9'd383, 9'd391, 9'd399, 9'd407, 9'd414, 9'd421,
        9'd428, 9'd435, 9'd441, 9'd448, 9'd454, 9'd459, 9'd465, 9'd470,
        9'd474, 9'd479, 9'd483, 9'd487, 9'd491, 9'd494, 9'd497, 9'd500,
        9'd502, 9'd505, 9'd506, 9'd508, 9'd509, 9'd510, 9'd511, 9'd511
    };

    typedef enum logic [1:0] {IDLE, SETTLE, SEARCH, LOCKED} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     settle_cnt, settle_nxt;
    logic [HW-1:0]     hit_cnt, hit_nxt;
    logic [MW-1:0]     miss_cnt, miss_nxt;
    logic              offset_step;

    logic [31:0]       acc;
    logic [31:0]       phase_offset;
    logic [32:0]       offset_sum;
    logic              sweep_wrap;

    logic [31:0]       phase_s1;
    logic              valid_s1;
    logic [1:0]        quad;
    logic [5:0]        idx;
    logic [5:0]        addr;
    logic [9:0]        lut_ext;
    logic signed [9:0] ref_q;
    logic              ref_valid_q;

    // ---------------- phase search FSM ----------------
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            hit_cnt    <= hit_nxt;
            miss_cnt   <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        settle_nxt  = settle_cnt;
        hit_nxt     = hit_cnt;
        miss_nxt    = miss_cnt;
        offset_step = 1'b0;
        // Dropping enable wins over everything and does not wait for a strobe.
        if (!bus.enable) begin
            state_nxt  = IDLE;
            settle_nxt = '0;
            hit_nxt    = '0;
            miss_nxt   = '0;
        end else if (bus.sample_en) begin
            case (state)
                IDLE: begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                    hit_nxt    = '0;
                    miss_nxt   = '0;
                end
                SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CNT - 1)) begin
                        state_nxt  = SEARCH;
                        settle_nxt = '0;
                        hit_nxt    = '0;
                    end else begin
                        settle_nxt = settle_cnt + 1'b1;
                    end
                end
                SEARCH: begin
                    if (bus.adjust) begin
                        if (hit_cnt == HW'(LOCK_CNT - 1)) begin
                            state_nxt = LOCKED;
                            hit_nxt   = '0;
                            miss_nxt  = '0;
                        end else begin
                            hit_nxt = hit_cnt + 1'b1;
                        end
                    end else begin
                        hit_nxt     = '0;
                        offset_step = 1'b1;
                        state_nxt   = SETTLE;
                        settle_nxt  = '0;
                    end
                end
                LOCKED: begin
                    if (!bus.adjust) begin
                        if (miss_cnt == MW'(LOSS_CNT - 1)) begin
                            state_nxt = SEARCH;
                            miss_nxt  = '0;
                            hit_nxt   = '0;
                        end else begin
                            miss_nxt = miss_cnt + 1'b1;
                        end
                    end else begin
                        miss_nxt = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- phase offset and wrap flag ----------------
    assign offset_sum = {1'b0, phase_offset} + {1'b0, PHASE_STEP};

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_offset <= '0;
            sweep_wrap   <= 1'b0;
        end else begin
            sweep_wrap <= 1'b0;
            if (offset_step) begin
                phase_offset <= offset_sum[31:0];
                sweep_wrap   <= offset_sum[32];
            end
        end
    end

    // ---------------- NCO pipeline ----------------
    // S0: capture phase from the pre-increment accumulator and the offset in
    // force at this strobe; an offset step on the same edge lands next sample.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc      <= '0;
            phase_s1 <= '0;
            valid_s1 <= 1'b0;
        end else begin
            valid_s1 <= bus.sample_en;
            if (bus.sample_en) begin
                acc      <= acc + FCW;
                phase_s1 <= acc + phase_offset;
            end
        end
    end

    // S1: fold the phase onto the quarter-wave table.
    assign quad    = phase_s1[31:30];
    assign idx     = phase_s1[29:24];
    assign addr    = quad[0] ? (6'd63 - idx) : idx;
    assign lut_ext = {1'b0, SINE_LUT[addr]};

    // S2: apply the half-wave sign and publish.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
        end else begin
            ref_valid_q <= valid_s1;
            if (valid_s1) begin
                ref_q <= quad[1] ? (10'd0 - lut_ext) : lut_ext;
            end
        end
    end

    assign bus.ref_out      = ref_q;
    assign bus.ref_valid    = ref_valid_q;
    assign bus.locked       = (state == LOCKED);
    assign bus.phase_offset = phase_offset;
    assign bus.sweep_wrap   = sweep_wrap;

endmodule
